// File: rtl/snn_ctrl_pkg.sv
// Shared types and constants for the SNN image sequencer.
// Optional macro SNN_ASCII_OUT_EN selects ASCII digit output on the UART.
package snn_ctrl_pkg;

  typedef enum logic [2:0] {
    LOAD,
    START,
    COMPUTE,
    TX,
    TX_WAIT
  } state_t;

  localparam int DEF_NUM_PIXELS  = 784;
  localparam int BYTES_PER_IMAGE = DEF_NUM_PIXELS / 8;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_ERR  = 8'h3F;

  function automatic logic [7:0] digit_to_byte(
    input logic [3:0] d
  );
`ifdef SNN_ASCII_OUT_EN
    if (d > 4'd9) return ASCII_ERR;
    return ASCII_ZERO + {4'h0, d};
`else
    return {4'h0, d};
`endif
  endfunction

endpackage

// File: rtl/snn_byte_unpacker.sv
// Serialises received bytes into one pixel bit per cycle, LSB first.
// Ports: rx byte in, enable/clear in; bit/we/addr/last_bit/drop/first out.
module snn_byte_unpacker
  import snn_ctrl_pkg::*;
#(
  parameter int NUM_PIXELS = DEF_NUM_PIXELS,
  parameter int ADDR_W     = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_rdy,
  input  logic              enable,
  input  logic              clear,
  output logic              wr_bit,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              last_bit,
  output logic              drop,
  output logic              first_accept
);

  localparam logic [ADDR_W-1:0] LAST_ADDR =
    ADDR_W'(NUM_PIXELS - 1);

  logic [7:0]        shift_q;
  logic [7:0]        hold_q;
  logic              hold_vld;
  logic              active;
  logic [2:0]        bit_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] byte_cnt;

  logic byte_end;
  logic take_shift;
  logic take_hold;
  logic accept;

  always_comb begin
    wr_en    = active;
    wr_bit   = active & shift_q[0];
    wr_addr  = addr_q;
    byte_end = active && (bit_cnt == 3'd7);
    last_bit = byte_end && (addr_q == LAST_ADDR);
    // On a byte's final bit with hold empty, a new byte goes
    // straight into the shifter so the stream has no bubble.
    take_shift = rx_rdy && enable && !last_bit &&
                 (!active || (byte_end && !hold_vld));
    take_hold  = rx_rdy && enable && !last_bit &&
                 active && !byte_end && !hold_vld;
    accept       = take_shift || take_hold;
    drop         = (rx_rdy && !accept) ||
                   (last_bit && hold_vld);
    first_accept = accept && (byte_cnt == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q  <= '0;
      hold_q   <= '0;
      hold_vld <= 1'b0;
      active   <= 1'b0;
      bit_cnt  <= '0;
      addr_q   <= '0;
      byte_cnt <= '0;
    end else if (clear) begin
      shift_q  <= '0;
      hold_q   <= '0;
      hold_vld <= 1'b0;
      active   <= 1'b0;
      bit_cnt  <= '0;
      addr_q   <= '0;
      byte_cnt <= '0;
    end else begin
      if (active) begin
        shift_q <= shift_q >> 1;
        bit_cnt <= bit_cnt + 3'd1;
        addr_q  <= addr_q + 1'b1;
      end
      if (last_bit) begin
        active   <= 1'b0;
        hold_vld <= 1'b0;
      end else if (byte_end) begin
        if (hold_vld) begin
          shift_q  <= hold_q;
          hold_vld <= 1'b0;
        end else if (take_shift) begin
          shift_q <= rx_data;
        end else begin
          active <= 1'b0;
        end
      end else if (take_shift) begin
        shift_q <= rx_data;
        active  <= 1'b1;
      end
      if (take_hold) begin
        hold_q   <= rx_data;
        hold_vld <= 1'b1;
      end
      if (accept) byte_cnt <= byte_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/snn_image_ctrl.sv
// Sequencer: UART rx -> pixel RAM -> snn_core -> UART tx.
// Macro SNN_ASCII_OUT_EN: send ASCII digit instead of raw nibble.
module snn_image_ctrl
  import snn_ctrl_pkg::*;
#(
  parameter int NUM_PIXELS = DEF_NUM_PIXELS,
  parameter int ADDR_W     = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_rdy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic              ram_data,
  output logic              snn_start,
  input  logic [ADDR_W-1:0] snn_addr,
  input  logic              snn_done,
  input  logic [3:0]        snn_digit,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_done,
  output logic              busy,
  output logic              overrun
);

  state_t state;

  logic              wr_bit;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              last_bit;
  logic              drop;
  logic              first_accept;
  logic              in_load;
  logic              clear;

  assign in_load = (state == LOAD);
  assign clear   = (state == TX_WAIT) && tx_done;

  snn_byte_unpacker #(
    .NUM_PIXELS (NUM_PIXELS),
    .ADDR_W     (ADDR_W)
  ) u_unpack (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_data      (rx_data),
    .rx_rdy       (rx_rdy),
    .enable       (in_load),
    .clear        (clear),
    .wr_bit       (wr_bit),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .last_bit     (last_bit),
    .drop         (drop),
    .first_accept (first_accept)
  );

  always_comb begin
    ram_addr = '0;
    ram_we   = 1'b0;
    ram_data = 1'b0;
    busy     = !in_load;
    unique case (state)
      LOAD: begin
        ram_addr = wr_addr;
        ram_we   = wr_en;
        ram_data = wr_bit;
      end
      START, COMPUTE: ram_addr = snn_addr;
      default: ram_addr = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LOAD;
      snn_start <= 1'b0;
      tx_start  <= 1'b0;
      tx_data   <= '0;
      overrun   <= 1'b0;
    end else begin
      snn_start <= 1'b0;
      tx_start  <= 1'b0;
      // A drop in the same cycle as a new image's first byte wins.
      if (drop)              overrun <= 1'b1;
      else if (first_accept) overrun <= 1'b0;
      unique case (state)
        LOAD: begin
          if (last_bit) begin
            state     <= START;
            snn_start <= 1'b1;
          end
        end
        START: state <= COMPUTE;
        COMPUTE: begin
          if (snn_done) begin
            tx_data  <= digit_to_byte(snn_digit);
            tx_start <= 1'b1;
            state    <= TX;
          end
        end
        TX: state <= TX_WAIT;
        TX_WAIT: begin
          if (tx_done) state <= LOAD;
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_snn_image_ctrl.sv
// Directed self-checking bench for snn_image_ctrl.
// Set SNN_ASCII_OUT_EN to match the DUT build.
module tb_snn_image_ctrl;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [7:0]        rx_data = '0;
  logic              rx_rdy = 1'b0;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic              ram_data;
  logic              snn_start;
  logic [ADDR_W-1:0] snn_addr = '0;
  logic              snn_done = 1'b0;
  logic [3:0]        snn_digit = '0;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              tx_done = 1'b0;
  logic              busy;
  logic              overrun;

  int checks = 0;
  int errors = 0;

  snn_image_ctrl #(
    .NUM_PIXELS (784),
    .ADDR_W     (ADDR_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_rdy    (rx_rdy),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_data  (ram_data),
    .snn_start (snn_start),
    .snn_addr  (snn_addr),
    .snn_done  (snn_done),
    .snn_digit (snn_digit),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .tx_done   (tx_done),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Passive RAM/handshake recorder, sampled on the falling edge.
  int   cyc = 0;
  int   we_cnt = 0;
  int   ones = 0;
  int   seq_bad = 0;
  int   start_cnt = 0;
  int   start_cyc = -1;
  int   last_we_cyc = -1;
  int   last_we_addr = -1;
  logic [ADDR_W-1:0] exp_addr = '0;
  bit   pix [0:1023];

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (!rst_n || busy) exp_addr = '0;
    if (ram_we) begin
      pix[ram_addr] = ram_data;
      if (ram_addr !== exp_addr) seq_bad = seq_bad + 1;
      exp_addr = ram_addr + 1'b1;
      we_cnt = we_cnt + 1;
      ones = ones + int'(ram_data);
      last_we_cyc = cyc;
      last_we_addr = int'(ram_addr);
    end
    if (snn_start) begin
      start_cnt = start_cnt + 1;
      start_cyc = cyc;
    end
  end

  function automatic logic [7:0] exp_tx(input logic [3:0] d);
`ifdef SNN_ASCII_OUT_EN
    if (d > 4'd9) return 8'h3F;
    return 8'h30 + {4'h0, d};
`else
    return {4'h0, d};
`endif
  endfunction

  function automatic logic [7:0] pix_byte(input int base);
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = pix[base + i];
    return v;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data = b;
    rx_rdy  = 1'b1;
    tick();
    rx_rdy  = 1'b0;
    repeat (gap - 1) tick();
  endtask

  task automatic finish_image(input logic [3:0] d);
    snn_addr = 10'd123;
    #2;
    checks++;
    if (ram_addr !== 10'd123) begin
      errors++;
      $display("FAIL compute_addr: got %0d want 123", ram_addr);
    end
    checks++;
    if (ram_we !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL compute_busy: we=%b busy=%b want 0/1",
               ram_we, busy);
    end
    tick();
    snn_digit = d;
    snn_done  = 1'b1;
    tick();
    snn_done  = 1'b0;
    checks++;
    if (tx_start !== 1'b1 || tx_data !== exp_tx(d)) begin
      errors++;
      $display("FAIL tx_launch: start=%b data=%h want 1/%h",
               tx_start, tx_data, exp_tx(d));
    end
    tick();
    checks++;
    if (tx_start !== 1'b0 || tx_data !== exp_tx(d)) begin
      errors++;
      $display("FAIL tx_hold: start=%b data=%h want 0/%h",
               tx_start, tx_data, exp_tx(d));
    end
    repeat (3) tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL back_to_load: busy=%b want 0", busy);
    end
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({busy, overrun, ram_we, ram_data, snn_start, tx_start}
        !== 6'b0 || ram_addr !== '0 || tx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: b%b o%b we%b d%b s%b t%b a%0d tx%h want all 0",
               busy, overrun, ram_we, ram_data, snn_start,
               tx_start, ram_addr, tx_data);
    end
    do_reset();
    snn_done  = 1'b1;
    snn_digit = 4'd5;
    tick();
    snn_done  = 1'b0;
    tick();
    checks++;
    if (tx_start !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_ignored: tx_start=%b busy=%b want 0/0",
               tx_start, busy);
    end
  endtask

  task automatic test_full_image;
    int w0, o0, q0, s0;
    w0 = we_cnt; o0 = ones; q0 = seq_bad; s0 = start_cnt;
    for (int k = 0; k < 98; k++) send_byte(8'hFF, 20);
    checks++;
    if (we_cnt - w0 != 784 || ones - o0 != 784) begin
      errors++;
      $display("FAIL ff_writes: we=%0d ones=%0d want 784/784",
               we_cnt - w0, ones - o0);
    end
    checks++;
    if (seq_bad != q0 || last_we_addr != 783) begin
      errors++;
      $display("FAIL ff_order: bad=%0d last=%0d want 0/783",
               seq_bad - q0, last_we_addr);
    end
    checks++;
    if (start_cnt - s0 != 1 || start_cyc != last_we_cyc + 1) begin
      errors++;
      $display("FAIL ff_start: n=%0d at %0d want 1 at %0d",
               start_cnt - s0, start_cyc, last_we_cyc + 1);
    end
    checks++;
    if (busy !== 1'b1 || snn_start !== 1'b0) begin
      errors++;
      $display("FAIL ff_busy: busy=%b start=%b want 1/0",
               busy, snn_start);
    end
    finish_image(4'd6);
  endtask

  task automatic test_first_byte_a5;
    send_byte(8'hA5, 20);
    checks++;
    if (pix_byte(0) !== 8'b1010_0101) begin
      errors++;
      $display("FAIL a5_bits: got %b want 10100101", pix_byte(0));
    end
  endtask

  task automatic test_reset_midway;
    int q0, s0;
    for (int k = 1; k < 40; k++) send_byte(8'h0F, 20);
    do_reset();
    checks++;
    if (busy !== 1'b0 || overrun !== 1'b0 || ram_we !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: busy=%b ovr=%b we=%b want 0",
               busy, overrun, ram_we);
    end
    q0 = seq_bad; s0 = start_cnt;
    for (int k = 0; k < 97; k++) send_byte(8'h3C, 20);
    checks++;
    if (start_cnt != s0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL early_start: n=%0d busy=%b want 0/0",
               start_cnt - s0, busy);
    end
    send_byte(8'h3C, 20);
    checks++;
    if (start_cnt - s0 != 1 || seq_bad != q0) begin
      errors++;
      $display("FAIL restart_image: starts=%0d bad=%0d want 1/0",
               start_cnt - s0, seq_bad - q0);
    end
    checks++;
    if (pix_byte(0) !== 8'h3C || pix_byte(776) !== 8'h3C) begin
      errors++;
      $display("FAIL restart_data: %h %h want 3c 3c",
               pix_byte(0), pix_byte(776));
    end
    finish_image(4'd9);
  endtask

  task automatic test_back_to_back;
    int w0, q0, c0;
    do_reset();
    w0 = we_cnt; q0 = seq_bad;
    c0 = cyc;
    rx_rdy  = 1'b1;
    rx_data = 8'h01;
    tick();
    rx_data = 8'h02;
    tick();
    rx_data = 8'h03;
    tick();
    rx_rdy  = 1'b0;
    repeat (20) tick();
    checks++;
    if (we_cnt - w0 != 16 || seq_bad != q0 ||
        last_we_cyc != c0 + 16) begin
      errors++;
      $display("FAIL b2b_stream: n=%0d bad=%0d end=%0d want 16/0/%0d",
               we_cnt - w0, seq_bad - q0, last_we_cyc, c0 + 16);
    end
    checks++;
    if (pix_byte(0) !== 8'h01 || pix_byte(8) !== 8'h02) begin
      errors++;
      $display("FAIL b2b_data: %h %h want 01 02",
               pix_byte(0), pix_byte(8));
    end
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL b2b_overrun: got %b want 1", overrun);
    end
  endtask

  task automatic test_rx_during_compute;
    int w0, o0, q0;
    do_reset();
    o0 = ones;
    for (int k = 0; k < 98; k++) send_byte(8'h55, 20);
    checks++;
    if (ones - o0 != 392 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL img55: ones=%0d ovr=%b want 392/0",
               ones - o0, overrun);
    end
    w0 = we_cnt;
    send_byte(8'h77, 20);
    checks++;
    if (overrun !== 1'b1 || we_cnt != w0) begin
      errors++;
      $display("FAIL compute_drop: ovr=%b we=%0d want 1/0",
               overrun, we_cnt - w0);
    end
    finish_image(4'd12);
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_sticky: got %b want 1", overrun);
    end
    w0 = we_cnt; q0 = seq_bad;
    send_byte(8'h80, 20);
    checks++;
    if (overrun !== 1'b0 || we_cnt - w0 != 8 ||
        seq_bad != q0 || pix_byte(0) !== 8'h80) begin
      errors++;
      $display("FAIL new_image: ovr=%b we=%0d bad=%0d d=%h want 0/8/0/80",
               overrun, we_cnt - w0, seq_bad - q0, pix_byte(0));
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_full_image();
    test_first_byte_a5();
    test_reset_midway();
    test_back_to_back();
    test_rx_during_compute();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
